instruction_decode: RTL and testbench



---
 rtl/instruction_decode.sv | 189 ++++++++++++++++++
 tb/tb_instruction_decode.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// ID stage for the MIPS subset: IF/ID register, 32x32 register file with write-first bypass,
// branch/jump resolution back to fetch, and the registered ID/EX bundle for EX.
module instruction_decode #(
  parameter logic [31:0] SP_INIT = 32'h7FFFEFFC,
  parameter logic [31:0] GP_INIT = 32'h10008000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_mode,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        branch_taken,
  output logic [31:0] next_pc,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_dest,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        ex_illegal
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
                         ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11,
                         ALU_PASS_B = 4'd12;

  logic        r_ifid_valid;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_regs [32];

  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_imm_sext, w_imm_zext, w_pc_plus4, w_br_target, w_j_target;
  logic [31:0] w_rs_data, w_rt_data;
  logic        w_legal, w_alu_src, w_mem_read, w_mem_write, w_reg_write, w_mem_to_reg;
  logic        w_is_beq, w_is_bne, w_is_jump, w_is_jr, w_load;
  logic [3:0]  w_alu_op;
  logic [4:0]  w_dest;
  logic [31:0] w_imm;

  assign w_opcode    = r_ifid_instr[31:26];
  assign w_rs        = r_ifid_instr[25:21];
  assign w_rt        = r_ifid_instr[20:16];
  assign w_rd        = r_ifid_instr[15:11];
  assign w_funct     = r_ifid_instr[5:0];
  assign w_imm_sext  = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
  assign w_imm_zext  = {16'h0000, r_ifid_instr[15:0]};
  assign w_pc_plus4  = r_ifid_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};
  assign w_j_target  = {w_pc_plus4[31:28], r_ifid_instr[25:0], 2'b00};

  // Write-first: a register being written this edge is read as the incoming data.
  assign w_rs_data = (w_rs == 5'd0) ? 32'h0 :
                     (wb_en && wb_addr == w_rs) ? wb_data : r_regs[w_rs];
  assign w_rt_data = (w_rt == 5'd0) ? 32'h0 :
                     (wb_en && wb_addr == w_rt) ? wb_data : r_regs[w_rt];

  always_comb begin
    w_legal      = 1'b1;
    w_alu_op     = ALU_ADD;
    w_alu_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_dest       = w_rt;
    w_imm        = w_imm_sext;
    w_is_beq     = 1'b0;
    w_is_bne     = 1'b0;
    w_is_jump    = 1'b0;
    w_is_jr      = 1'b0;
    case (w_opcode)
      6'h00: begin
        w_dest      = w_rd;
        w_reg_write = 1'b1;
        case (w_funct)
          6'h20, 6'h21: w_alu_op = ALU_ADD;
          6'h22, 6'h23: w_alu_op = ALU_SUB;
          6'h24:        w_alu_op = ALU_AND;
          6'h25:        w_alu_op = ALU_OR;
          6'h26:        w_alu_op = ALU_XOR;
          6'h27:        w_alu_op = ALU_NOR;
          6'h2A:        w_alu_op = ALU_SLT;
          6'h2B:        w_alu_op = ALU_SLTU;
          6'h00:        w_alu_op = ALU_SLL;
          6'h02:        w_alu_op = ALU_SRL;
          6'h03:        w_alu_op = ALU_SRA;
          6'h08: begin w_reg_write = 1'b0; w_is_jr = 1'b1; end
          default: begin w_legal = 1'b0; w_reg_write = 1'b0; end
        endcase
      end
      6'h08, 6'h09: begin w_alu_src = 1'b1; w_reg_write = 1'b1; end
      6'h0A: begin w_alu_op = ALU_SLT;  w_alu_src = 1'b1; w_reg_write = 1'b1; end
      6'h0B: begin w_alu_op = ALU_SLTU; w_alu_src = 1'b1; w_reg_write = 1'b1; end
      6'h0C: begin w_alu_op = ALU_AND; w_alu_src = 1'b1; w_reg_write = 1'b1; w_imm = w_imm_zext; end
      6'h0D: begin w_alu_op = ALU_OR;  w_alu_src = 1'b1; w_reg_write = 1'b1; w_imm = w_imm_zext; end
      6'h0E: begin w_alu_op = ALU_XOR; w_alu_src = 1'b1; w_reg_write = 1'b1; w_imm = w_imm_zext; end
      6'h0F: begin w_alu_op = ALU_LUI; w_alu_src = 1'b1; w_reg_write = 1'b1; w_imm = w_imm_zext; end
      6'h23: begin w_alu_src = 1'b1; w_mem_read = 1'b1; w_mem_to_reg = 1'b1; w_reg_write = 1'b1; end
      6'h2B: begin w_alu_src = 1'b1; w_mem_write = 1'b1; end
      6'h04: w_is_beq = 1'b1;
      6'h05: w_is_bne = 1'b1;
      6'h02: w_is_jump = 1'b1;
      // jal hands the link address to EX as the immediate and passes it through the ALU.
      6'h03: begin
        w_is_jump   = 1'b1;
        w_alu_op    = ALU_PASS_B;
        w_alu_src   = 1'b1;
        w_imm       = r_ifid_pc + 32'd8;
        w_dest      = 5'd31;
        w_reg_write = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_load = r_ifid_valid && w_legal;

  always_comb begin
    branch_taken = 1'b0;
    next_pc      = w_pc_plus4;
    if (r_ifid_valid && !init_mode) begin
      if ((w_is_beq && w_rs_data == w_rt_data) || (w_is_bne && w_rs_data != w_rt_data)) begin
        branch_taken = 1'b1;
        next_pc      = w_br_target;
      end else if (w_is_jump) begin
        branch_taken = 1'b1;
        next_pc      = w_j_target;
      end else if (w_is_jr) begin
        branch_taken = 1'b1;
        next_pc      = w_rs_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 32'h0;
      r_ifid_instr <= 32'h0;
    end else if (init_mode) begin
      r_ifid_valid <= 1'b0;
    end else begin
      r_ifid_valid <= 1'b1;
      r_ifid_pc    <= pc_in;
      r_ifid_instr <= instr_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
      r_regs[28] <= GP_INIT;
      r_regs[29] <= SP_INIT;
    end else if (wb_en && wb_addr != 5'd0) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0; ex_pc <= 32'h0; ex_rs_data <= 32'h0; ex_rt_data <= 32'h0;
      ex_imm <= 32'h0; ex_shamt <= 5'd0; ex_dest <= 5'd0; ex_alu_op <= 4'd0;
      ex_alu_src <= 1'b0; ex_mem_read <= 1'b0; ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0; ex_mem_to_reg <= 1'b0; ex_illegal <= 1'b0;
    end else if (w_load) begin
      ex_valid <= 1'b1; ex_pc <= r_ifid_pc; ex_rs_data <= w_rs_data; ex_rt_data <= w_rt_data;
      ex_imm <= w_imm; ex_shamt <= r_ifid_instr[10:6]; ex_dest <= w_dest; ex_alu_op <= w_alu_op;
      ex_alu_src <= w_alu_src; ex_mem_read <= w_mem_read; ex_mem_write <= w_mem_write;
      ex_reg_write <= w_reg_write; ex_mem_to_reg <= w_mem_to_reg; ex_illegal <= 1'b0;
    end else begin
      ex_valid <= 1'b0; ex_pc <= 32'h0; ex_rs_data <= 32'h0; ex_rt_data <= 32'h0;
      ex_imm <= 32'h0; ex_shamt <= 5'd0; ex_dest <= 5'd0; ex_alu_op <= 4'd0;
      ex_alu_src <= 1'b0; ex_mem_read <= 1'b0; ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0; ex_mem_to_reg <= 1'b0; ex_illegal <= r_ifid_valid;
    end
  end
endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios plus random instruction streams,
// checked against an instruction-level reference model of IF/ID, regfile and decode.
module tb_instruction_decode;
  localparam logic [31:0] SP_INIT = 32'h7FFFEFFC;
  localparam logic [31:0] GP_INIT = 32'h10008000;

  logic        clk = 1'b0;
  logic        reset, init_mode, wb_en;
  logic [31:0] pc_in, instr_in, wb_data;
  logic [4:0]  wb_addr;
  logic        branch_taken, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write;
  logic        ex_reg_write, ex_mem_to_reg, ex_illegal;
  logic [31:0] next_pc, ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_shamt, ex_dest;
  logic [3:0]  ex_alu_op;

  always #5 clk = ~clk;

  instruction_decode #(.SP_INIT(SP_INIT), .GP_INIT(GP_INIT)) dut (
    .clk(clk), .reset(reset), .init_mode(init_mode), .pc_in(pc_in), .instr_in(instr_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .branch_taken(branch_taken), .next_pc(next_pc),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal)
  );

  typedef struct {
    bit          valid, illegal, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    bit          chk_imm;
    logic [3:0]  alu_op;
    logic [31:0] pc, rs_v, rt_v, imm;
    logic [4:0]  dest, shamt;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  bit          m_valid;
  logic [31:0] m_pc, m_instr;
  logic [5:0]  fn_list [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_regs[28] = GP_INIT;
    m_regs[29] = SP_INIT;
    m_valid = 0; m_pc = 32'h0; m_instr = 32'h0;
  endtask

  // What the instruction in IF/ID should turn into on the ID/EX register.
  function automatic exp_t model_ex();
    exp_t e;
    logic [5:0] op, fn;
    logic [31:0] se, ze;
    e = '{default: 0};
    if (!m_valid) return e;
    op = m_instr[31:26]; fn = m_instr[5:0];
    se = {{16{m_instr[15]}}, m_instr[15:0]};
    ze = {16'h0, m_instr[15:0]};
    e.valid = 1; e.pc = m_pc; e.shamt = m_instr[10:6];
    e.rs_v = m_read(m_instr[25:21]); e.rt_v = m_read(m_instr[20:16]);
    e.dest = m_instr[20:16];
    if (op == 6'h00) begin
      e.dest = m_instr[15:11]; e.reg_write = 1;
      case (fn)
        6'h20, 6'h21: e.alu_op = 0;
        6'h22, 6'h23: e.alu_op = 1;
        6'h24: e.alu_op = 2;  6'h25: e.alu_op = 3;  6'h26: e.alu_op = 4;
        6'h27: e.alu_op = 5;  6'h2A: e.alu_op = 6;  6'h2B: e.alu_op = 7;
        6'h00: e.alu_op = 8;  6'h02: e.alu_op = 9;  6'h03: e.alu_op = 10;
        6'h08: e.reg_write = 0;
        default: e.illegal = 1;
      endcase
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      e.alu_src = 1; e.reg_write = 1; e.chk_imm = (op != 6'h0F);
      e.imm = (op >= 6'h0C) ? ze : se;
      case (op)
        6'h0A: e.alu_op = 6;  6'h0B: e.alu_op = 7;  6'h0C: e.alu_op = 2;
        6'h0D: e.alu_op = 3;  6'h0E: e.alu_op = 4;  6'h0F: e.alu_op = 11;
        default: e.alu_op = 0;
      endcase
    end else if (op == 6'h23) begin
      e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1; e.chk_imm = 1; e.imm = se;
    end else if (op == 6'h2B) begin
      e.alu_src = 1; e.mem_write = 1; e.chk_imm = 1; e.imm = se;
    end else if (op == 6'h03) begin
      e.alu_op = 12; e.alu_src = 1; e.imm = m_pc + 8; e.chk_imm = 1; e.dest = 31; e.reg_write = 1;
    end else if (!(op == 6'h02 || op == 6'h04 || op == 6'h05)) begin
      e.illegal = 1;
    end
    if (e.illegal) begin e = '{default: 0}; e.illegal = 1; end
    return e;
  endfunction

  task automatic model_branch(output bit bt, output logic [31:0] np);
    logic [5:0]  op;
    logic [31:0] a, b, off;
    op = m_instr[31:26];
    a = m_read(m_instr[25:21]); b = m_read(m_instr[20:16]);
    off = {{14{m_instr[15]}}, m_instr[15:0], 2'b00};
    bt = 0; np = m_pc + 4;
    if (m_valid && !init_mode) begin
      if ((op == 6'h04 && a == b) || (op == 6'h05 && a != b)) begin
        bt = 1; np = m_pc + 4 + off;
      end else if (op == 6'h02 || op == 6'h03) begin
        bt = 1; np = (m_pc + 4) & 32'hF000_0000 | {4'h0, m_instr[25:0], 2'b00};
      end else if (op == 6'h00 && m_instr[5:0] == 6'h08) begin
        bt = 1; np = a;
      end
    end
  endtask

  task automatic check_ex(input exp_t e);
    check("ex_valid", ex_valid, e.valid);
    check("ex_illegal", ex_illegal, e.illegal);
    check("ex_reg_write", ex_reg_write, e.reg_write);
    check("ex_mem_read", ex_mem_read, e.mem_read);
    check("ex_mem_write", ex_mem_write, e.mem_write);
    check("ex_mem_to_reg", ex_mem_to_reg, e.mem_to_reg);
    check("ex_alu_src", ex_alu_src, e.alu_src);
    check("ex_alu_op", ex_alu_op, e.alu_op);
    if (e.valid) begin
      check("ex_pc", ex_pc, e.pc);
      check("ex_rs_data", ex_rs_data, e.rs_v);
      check("ex_rt_data", ex_rt_data, e.rt_v);
      check("ex_shamt", ex_shamt, e.shamt);
      if (e.chk_imm) check("ex_imm", ex_imm, e.imm);
      if (e.reg_write) check("ex_dest", ex_dest, e.dest);
    end
  endtask

  // One clock with the currently driven inputs; called just after a falling edge.
  task automatic cycle();
    bit bt;
    logic [31:0] np;
    #1;
    model_branch(bt, np);
    check("branch_taken", branch_taken, bt);
    if (m_valid && !init_mode) check("next_pc", next_pc, np);
    exp_q.push_back(model_ex());
    @(posedge clk);
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    if (init_mode) m_valid = 0;
    else begin m_valid = 1; m_pc = pc_in; m_instr = instr_in; end
    @(negedge clk);
    check_ex(exp_q.pop_front());
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
    pc_in = pc; instr_in = ins; wb_en = 0; wb_addr = 0; wb_data = 0; init_mode = 0;
  endtask

  function automatic logic [4:0] rand_reg();
    logic [2:0] k;
    k = 3'($urandom_range(0, 7));
    case (k)
      3'd4: return 5'd28;
      3'd5: return 5'd29;
      3'd6: return 5'd31;
      3'd7: return 5'($urandom_range(0, 31));
      default: return {3'b000, k[1:0]};
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [15:0] imm;
    logic [5:0]  fn;
    imm = 16'($urandom);
    fn = fn_list[$urandom_range(0, 13)];
    case ($urandom_range(0, 9))
      0: return enc_r(rand_reg(), rand_reg(), rand_reg(), $urandom_range(0, 31), fn);
      1: return enc_i(6'($urandom_range(8, 15)), rand_reg(), rand_reg(), imm);
      2: return enc_i(6'h23, rand_reg(), rand_reg(), imm);
      3: return enc_i(6'h2B, rand_reg(), rand_reg(), imm);
      4: return enc_i(6'h04, rand_reg(), rand_reg(), imm);
      5: return enc_i(6'h05, rand_reg(), rand_reg(), imm);
      6: return {6'h02, 26'($urandom)};
      7: return {6'h03, 26'($urandom)};
      8: return enc_r(rand_reg(), 0, 0, 0, 6'h08);
      default: return ($urandom_range(0, 1) == 1) ? {6'h3F, 26'($urandom)}
                                                   : enc_r(rand_reg(), rand_reg(), 1, 0, 6'h3F);
    endcase
  endfunction

  initial begin
    reset = 1; drive(32'h0, 32'h0);
    m_reset();
    @(negedge clk); @(negedge clk);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_branch_taken", branch_taken, 0);
    check("rst_ex_reg_write", ex_reg_write, 0);
    reset = 0;

    // addi $8,$0,5 reaches EX after its second edge
    drive(32'h00400000, enc_i(6'h08, 0, 8, 16'd5)); cycle();
    drive(32'h00400004, 32'h0); cycle();
    check("addi_imm", ex_imm, 32'd5);
    check("addi_dest", ex_dest, 5'd8);
    check("addi_alu_op", ex_alu_op, 4'd0);
    check("addi_alu_src", ex_alu_src, 1);

    // write-first bypass on $9, and $0 ignores writes
    drive(32'h00400008, enc_r(9, 0, 10, 0, 6'h20)); cycle();
    drive(32'h0040000C, 32'h0); wb_en = 1; wb_addr = 9; wb_data = 32'hDEADBEEF; cycle();
    check("bypass_rs", ex_rs_data, 32'hDEADBEEF);
    drive(32'h00400010, enc_r(0, 9, 11, 0, 6'h20)); cycle();
    drive(32'h00400014, 32'h0); wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF; cycle();
    check("r0_bypass", ex_rs_data, 32'h0);
    check("r9_stored", ex_rt_data, 32'hDEADBEEF);

    // beq $0,$0,-1 loops on itself; bne $0,$0 falls through
    drive(32'h00400008, enc_i(6'h04, 0, 0, 16'hFFFF)); cycle();
    #1 check("beq_taken", branch_taken, 1);
    check("beq_target", next_pc, 32'h00400008);
    drive(32'h00400008, enc_i(6'h05, 0, 0, 16'hFFFF)); cycle();
    #1 check("bne_taken", branch_taken, 0);
    check("bne_next_pc", next_pc, 32'h0040000C);

    // jal
    drive(32'h00400010, {6'h03, 26'h0100004}); cycle();
    #1 check("jal_taken", branch_taken, 1);
    check("jal_target", next_pc, 32'h00400010);
    drive(32'h00400014, 32'h0); cycle();
    check("jal_dest", ex_dest, 5'd31);
    check("jal_link", ex_imm, 32'h00400018);
    check("jal_reg_write", ex_reg_write, 1);

    // branch target wraps past the top of the address space
    drive(32'hFFFFFFF8, enc_i(6'h04, 0, 0, 16'h0001)); cycle();
    drive(32'hFFFFFFFC, 32'h0); cycle();

    // illegal opcode becomes a flagged bubble
    drive(32'h00400020, 32'hFC000000); cycle();
    drive(32'h00400024, 32'h0); cycle();
    check("ill_flag", ex_illegal, 1);
    check("ill_valid", ex_valid, 0);
    check("ill_reg_write", ex_reg_write, 0);

    // init_mode suppresses redirects and bubbles the stage, writes still land
    drive(32'h00400028, enc_i(6'h04, 0, 0, 16'h0010)); cycle();
    init_mode = 1; wb_en = 1; wb_addr = 5; wb_data = 32'h12345678;
    #1 check("init_no_branch", branch_taken, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(32'h00400030, enc_i(6'h04, 0, 0, 16'h0010)); init_mode = 1; cycle();
    end
    drive(32'h00400040, enc_r(5, 29, 6, 0, 6'h20)); cycle();
    drive(32'h00400044, 32'h0); cycle();

    // reset mid-stream with lw in IF/ID and another in EX
    drive(32'h00400050, enc_i(6'h23, 29, 3, 16'd4)); wb_en = 1; wb_addr = 29; wb_data = 32'h11112222; cycle();
    drive(32'h00400054, enc_i(6'h23, 29, 4, 16'd8)); cycle();
    reset = 1;
    #1;
    check("mrst_ex_valid", ex_valid, 0);
    check("mrst_mem_read", ex_mem_read, 0);
    check("mrst_reg_write", ex_reg_write, 0);
    check("mrst_ex_pc", ex_pc, 32'h0);
    check("mrst_ex_rs", ex_rs_data, 32'h0);
    check("mrst_ex_imm", ex_imm, 32'h0);
    check("mrst_ex_dest", ex_dest, 5'd0);
    check("mrst_branch", branch_taken, 0);
    check("mrst_sp", dut.r_regs[29], SP_INIT);
    check("mrst_gp", dut.r_regs[28], GP_INIT);
    m_reset();
    @(negedge clk);
    reset = 0;
    drive(32'h00400000, enc_r(29, 28, 2, 0, 6'h20)); cycle();
    drive(32'h00400004, 32'h0); cycle();

    // random streams
    for (int k = 0; k < 400; k++) begin
      pc_in = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc_in + 32'd4;
      instr_in = rand_instr();
      wb_en = 1'($urandom_range(0, 1));
      wb_addr = rand_reg();
      wb_data = $urandom;
      init_mode = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
